// File: rtl/mc_ctrl_pkg.sv
// Shared encodings for the multi-cycle CPU control FSM: states, opcodes, functs,
// ALU codes, mux selects and the decoded control-word layout.
package mc_ctrl_pkg;

  localparam int unsigned STATE_W    = 4;
  localparam int unsigned OP_W       = 6;
  localparam int unsigned FUNCT_W    = 6;
  localparam int unsigned ALU_CTRL_W = 4;
  localparam int unsigned SRC_B_W    = 2;
  localparam int unsigned PC_SRC_W   = 2;

  typedef enum logic [STATE_W-1:0] {
    S_RESET    = 4'd0,
    S_FETCH    = 4'd1,
    S_DECODE   = 4'd2,
    S_MEM_ADDR = 4'd3,
    S_MEM_RD   = 4'd4,
    S_MEM_WB   = 4'd5,
    S_MEM_WR   = 4'd6,
    S_R_EXEC   = 4'd7,
    S_R_WB     = 4'd8,
    S_BRANCH   = 4'd9,
    S_JUMP     = 4'd10,
    S_I_EXEC   = 4'd11,
    S_I_WB     = 4'd12,
    S_TRAP     = 4'd15
  } state_e;

  localparam logic [OP_W-1:0] OP_RTYPE = 6'b000000;
  localparam logic [OP_W-1:0] OP_LW    = 6'b100011;
  localparam logic [OP_W-1:0] OP_SW    = 6'b101011;
  localparam logic [OP_W-1:0] OP_BEQ   = 6'b000100;
  localparam logic [OP_W-1:0] OP_BNE   = 6'b000101;
  localparam logic [OP_W-1:0] OP_J     = 6'b000010;
  localparam logic [OP_W-1:0] OP_ADDI  = 6'b001000;

  localparam logic [FUNCT_W-1:0] FN_ADD = 6'b100000;
  localparam logic [FUNCT_W-1:0] FN_SUB = 6'b100010;
  localparam logic [FUNCT_W-1:0] FN_AND = 6'b100100;
  localparam logic [FUNCT_W-1:0] FN_OR  = 6'b100101;
  localparam logic [FUNCT_W-1:0] FN_SLT = 6'b101010;

  localparam logic [ALU_CTRL_W-1:0] ALU_AND = 4'b0000;
  localparam logic [ALU_CTRL_W-1:0] ALU_OR  = 4'b0001;
  localparam logic [ALU_CTRL_W-1:0] ALU_ADD = 4'b0010;
  localparam logic [ALU_CTRL_W-1:0] ALU_SUB = 4'b0110;
  localparam logic [ALU_CTRL_W-1:0] ALU_SLT = 4'b0111;

  localparam logic [SRC_B_W-1:0] SRC_B_REG     = 2'b00;
  localparam logic [SRC_B_W-1:0] SRC_B_FOUR    = 2'b01;
  localparam logic [SRC_B_W-1:0] SRC_B_IMM     = 2'b10;
  localparam logic [SRC_B_W-1:0] SRC_B_IMM_SH2 = 2'b11;

  localparam logic [PC_SRC_W-1:0] PC_SRC_ALU    = 2'b00;
  localparam logic [PC_SRC_W-1:0] PC_SRC_ALUOUT = 2'b01;
  localparam logic [PC_SRC_W-1:0] PC_SRC_JUMP   = 2'b10;

  // One decoded control word per cycle
  typedef struct packed {
    logic                  pc_we;
    logic                  ir_we;
    logic                  mdr_we;
    logic                  ab_we;
    logic                  alu_out_we;
    logic                  mem_rd;
    logic                  mem_wr;
    logic                  iord;
    logic                  reg_we;
    logic                  reg_dst;
    logic                  mem_to_reg;
    logic                  alu_src_a;
    logic [SRC_B_W-1:0]    alu_src_b;
    logic [ALU_CTRL_W-1:0] alu_ctrl;
    logic [PC_SRC_W-1:0]   pc_src;
    logic                  done;
    logic                  illegal;
  } ctrl_t;

endpackage

// File: rtl/mc_ctrl_if.sv
// Control bundle between mc_ctrl_fsm (master) and the multi-cycle datapath/memory (slave).
interface mc_ctrl_if;
  import mc_ctrl_pkg::*;

  logic [OP_W-1:0]       opcode;
  logic [FUNCT_W-1:0]    funct;
  logic                  zero;
  logic                  mem_ready;
  logic                  pc_we;
  logic                  ir_we;
  logic                  mdr_we;
  logic                  ab_we;
  logic                  alu_out_we;
  logic                  mem_rd;
  logic                  mem_wr;
  logic                  iord;
  logic                  reg_we;
  logic                  reg_dst;
  logic                  mem_to_reg;
  logic                  alu_src_a;
  logic [SRC_B_W-1:0]    alu_src_b;
  logic [ALU_CTRL_W-1:0] alu_ctrl;
  logic [PC_SRC_W-1:0]   pc_src;
  logic                  done;
  logic                  illegal;
  logic [STATE_W-1:0]    state;

  modport master (
    input  opcode, funct, zero, mem_ready,
    output pc_we, ir_we, mdr_we, ab_we, alu_out_we, mem_rd, mem_wr, iord,
           reg_we, reg_dst, mem_to_reg, alu_src_a, alu_src_b, alu_ctrl,
           pc_src, done, illegal, state
  );

  modport slave (
    output opcode, funct, zero, mem_ready,
    input  pc_we, ir_we, mdr_we, ab_we, alu_out_we, mem_rd, mem_wr, iord,
           reg_we, reg_dst, mem_to_reg, alu_src_a, alu_src_b, alu_ctrl,
           pc_src, done, illegal, state
  );

endinterface

// File: rtl/mc_alu_dec.sv
// R-type funct decoder: maps funct to an ALU operation and flags unsupported functs.
module mc_alu_dec
  import mc_ctrl_pkg::*;
(
  input  logic [FUNCT_W-1:0]    funct,
  output logic [ALU_CTRL_W-1:0] alu_ctrl_c,
  output logic                  valid_c
);

  always_comb begin
    alu_ctrl_c = ALU_ADD;
    valid_c    = 1'b1;
    case (funct)
      FN_ADD:  alu_ctrl_c = ALU_ADD;
      FN_SUB:  alu_ctrl_c = ALU_SUB;
      FN_AND:  alu_ctrl_c = ALU_AND;
      FN_OR:   alu_ctrl_c = ALU_OR;
      FN_SLT:  alu_ctrl_c = ALU_SLT;
      default: valid_c    = 1'b0;
    endcase
  end

endmodule

// File: rtl/mc_ctrl_fsm.sv
// Multi-cycle CPU main control FSM (Moore outputs plus mem_ready/zero qualifiers).
// Define MC_CTRL_BNE_EN to decode bne (opcode 000101) through BRANCH; otherwise it traps.
module mc_ctrl_fsm
  import mc_ctrl_pkg::*;
(
  input  logic       clk,
  input  logic       rst,
  mc_ctrl_if.master  bus
);

  state_e                state_q;
  state_e                state_d;
  logic                  rst_done_q;
  ctrl_t                 ctrl_c;
  logic [ALU_CTRL_W-1:0] dec_alu_ctrl_c;
  logic                  dec_valid_c;

  mc_alu_dec u_alu_dec (
    .funct      (bus.funct),
    .alu_ctrl_c (dec_alu_ctrl_c),
    .valid_c    (dec_valid_c)
  );

  // rst_done_q holds RESET for one extra edge so FETCH starts on the second edge after release
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= S_RESET;
      rst_done_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      rst_done_q <= 1'b1;
    end
  end

  always_comb begin
    state_d         = state_q;
    ctrl_c          = '0;
    ctrl_c.alu_ctrl = ALU_ADD;
    case (state_q)
      S_RESET: begin
        ctrl_c.alu_ctrl = '0;
        if (rst_done_q) state_d = S_FETCH;
      end
      S_FETCH: begin
        ctrl_c.mem_rd    = 1'b1;
        ctrl_c.alu_src_b = SRC_B_FOUR;
        ctrl_c.ir_we     = bus.mem_ready;
        ctrl_c.pc_we     = bus.mem_ready;
        if (bus.mem_ready) state_d = S_DECODE;
      end
      S_DECODE: begin
        ctrl_c.alu_src_b  = SRC_B_IMM_SH2;
        ctrl_c.ab_we      = 1'b1;
        ctrl_c.alu_out_we = 1'b1;
        case (bus.opcode)
          OP_RTYPE:     state_d = S_R_EXEC;
          OP_LW, OP_SW: state_d = S_MEM_ADDR;
          OP_BEQ:       state_d = S_BRANCH;
`ifdef MC_CTRL_BNE_EN
          OP_BNE:       state_d = S_BRANCH;
`endif
          OP_J:         state_d = S_JUMP;
          OP_ADDI:      state_d = S_I_EXEC;
          default:      state_d = S_TRAP;
        endcase
      end
      S_MEM_ADDR: begin
        ctrl_c.alu_src_a  = 1'b1;
        ctrl_c.alu_src_b  = SRC_B_IMM;
        ctrl_c.alu_out_we = 1'b1;
        state_d = (bus.opcode == OP_LW) ? S_MEM_RD : S_MEM_WR;
      end
      S_MEM_RD: begin
        ctrl_c.mem_rd = 1'b1;
        ctrl_c.iord   = 1'b1;
        ctrl_c.mdr_we = bus.mem_ready;
        if (bus.mem_ready) state_d = S_MEM_WB;
      end
      S_MEM_WB: begin
        ctrl_c.reg_we     = 1'b1;
        ctrl_c.mem_to_reg = 1'b1;
        ctrl_c.done       = 1'b1;
        state_d = S_FETCH;
      end
      S_MEM_WR: begin
        ctrl_c.mem_wr = 1'b1;
        ctrl_c.iord   = 1'b1;
        ctrl_c.done   = bus.mem_ready;
        if (bus.mem_ready) state_d = S_FETCH;
      end
      S_R_EXEC: begin
        ctrl_c.alu_src_a = 1'b1;
        ctrl_c.alu_src_b = SRC_B_REG;
        if (dec_valid_c) begin
          ctrl_c.alu_ctrl   = dec_alu_ctrl_c;
          ctrl_c.alu_out_we = 1'b1;
          state_d = S_R_WB;
        end else begin
          state_d = S_TRAP;
        end
      end
      S_R_WB: begin
        ctrl_c.reg_we  = 1'b1;
        ctrl_c.reg_dst = 1'b1;
        ctrl_c.done    = 1'b1;
        state_d = S_FETCH;
      end
      S_BRANCH: begin
        ctrl_c.alu_src_a = 1'b1;
        ctrl_c.alu_src_b = SRC_B_REG;
        ctrl_c.alu_ctrl  = ALU_SUB;
        ctrl_c.pc_src    = PC_SRC_ALUOUT;
`ifdef MC_CTRL_BNE_EN
        ctrl_c.pc_we     = (bus.opcode == OP_BNE) ? ~bus.zero : bus.zero;
`else
        ctrl_c.pc_we     = bus.zero;
`endif
        ctrl_c.done      = 1'b1;
        state_d = S_FETCH;
      end
      S_JUMP: begin
        ctrl_c.pc_src = PC_SRC_JUMP;
        ctrl_c.pc_we  = 1'b1;
        ctrl_c.done   = 1'b1;
        state_d = S_FETCH;
      end
      S_I_EXEC: begin
        ctrl_c.alu_src_a  = 1'b1;
        ctrl_c.alu_src_b  = SRC_B_IMM;
        ctrl_c.alu_out_we = 1'b1;
        state_d = S_I_WB;
      end
      S_I_WB: begin
        ctrl_c.reg_we = 1'b1;
        ctrl_c.done   = 1'b1;
        state_d = S_FETCH;
      end
      S_TRAP: begin
        ctrl_c.illegal = 1'b1;
      end
      default: state_d = S_TRAP;
    endcase
  end

  assign bus.pc_we      = ctrl_c.pc_we;
  assign bus.ir_we      = ctrl_c.ir_we;
  assign bus.mdr_we     = ctrl_c.mdr_we;
  assign bus.ab_we      = ctrl_c.ab_we;
  assign bus.alu_out_we = ctrl_c.alu_out_we;
  assign bus.mem_rd     = ctrl_c.mem_rd;
  assign bus.mem_wr     = ctrl_c.mem_wr;
  assign bus.iord       = ctrl_c.iord;
  assign bus.reg_we     = ctrl_c.reg_we;
  assign bus.reg_dst    = ctrl_c.reg_dst;
  assign bus.mem_to_reg = ctrl_c.mem_to_reg;
  assign bus.alu_src_a  = ctrl_c.alu_src_a;
  assign bus.alu_src_b  = ctrl_c.alu_src_b;
  assign bus.alu_ctrl   = ctrl_c.alu_ctrl;
  assign bus.pc_src     = ctrl_c.pc_src;
  assign bus.done       = ctrl_c.done;
  assign bus.illegal    = ctrl_c.illegal;
  assign bus.state      = STATE_W'(state_q);

endmodule

// File: tb/tb_mc_ctrl_fsm.sv
// Directed bench for mc_ctrl_fsm: per-cycle state and full control-word checks.
// Honours MC_CTRL_BNE_EN for the bne case.
module tb_mc_ctrl_fsm;

  logic clk = 1'b0;
  logic rst;
  int   n_total = 0;
  int   n_bad   = 0;

  mc_ctrl_if bus ();

  mc_ctrl_fsm dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;

  // Control-word bit masks, layout {pc_we..alu_src_a, src_b[1:0], alu_ctrl[3:0], pc_src[1:0], done, illegal}
  localparam logic [21:0] PCWE   = 22'h20_0000;
  localparam logic [21:0] IRWE   = 22'h10_0000;
  localparam logic [21:0] MDRWE  = 22'h08_0000;
  localparam logic [21:0] ABWE   = 22'h04_0000;
  localparam logic [21:0] AOWE   = 22'h02_0000;
  localparam logic [21:0] MRD    = 22'h01_0000;
  localparam logic [21:0] MWR    = 22'h00_8000;
  localparam logic [21:0] IORD   = 22'h00_4000;
  localparam logic [21:0] REGWE  = 22'h00_2000;
  localparam logic [21:0] REGDST = 22'h00_1000;
  localparam logic [21:0] M2R    = 22'h00_0800;
  localparam logic [21:0] SRCA   = 22'h00_0400;
  localparam logic [21:0] SB4    = 22'h00_0100;
  localparam logic [21:0] SBIMM  = 22'h00_0200;
  localparam logic [21:0] SBSH   = 22'h00_0300;
  localparam logic [21:0] A_AND  = 22'h00_0000;
  localparam logic [21:0] A_OR   = 22'h00_0010;
  localparam logic [21:0] A_ADD  = 22'h00_0020;
  localparam logic [21:0] A_SUB  = 22'h00_0060;
  localparam logic [21:0] A_SLT  = 22'h00_0070;
  localparam logic [21:0] PS_AO  = 22'h00_0004;
  localparam logic [21:0] PS_J   = 22'h00_0008;
  localparam logic [21:0] DONE   = 22'h00_0002;
  localparam logic [21:0] ILL    = 22'h00_0001;

  localparam logic [21:0] W_FETCH    = MRD | SB4 | A_ADD | PCWE | IRWE;
  localparam logic [21:0] W_FETCH_WT = MRD | SB4 | A_ADD;
  localparam logic [21:0] W_DEC      = SBSH | ABWE | AOWE | A_ADD;
  localparam logic [21:0] W_MADDR    = SRCA | SBIMM | AOWE | A_ADD;
  localparam logic [21:0] W_MRD      = MRD | IORD | MDRWE | A_ADD;
  localparam logic [21:0] W_MRD_WT   = MRD | IORD | A_ADD;
  localparam logic [21:0] W_MWB      = REGWE | M2R | DONE | A_ADD;
  localparam logic [21:0] W_MWR      = MWR | IORD | DONE | A_ADD;
  localparam logic [21:0] W_MWR_WT   = MWR | IORD | A_ADD;
  localparam logic [21:0] W_RWB      = REGWE | REGDST | DONE | A_ADD;
  localparam logic [21:0] W_BR_T     = SRCA | A_SUB | PS_AO | PCWE | DONE;
  localparam logic [21:0] W_BR_N     = SRCA | A_SUB | PS_AO | DONE;
  localparam logic [21:0] W_JMP      = PS_J | PCWE | DONE | A_ADD;
  localparam logic [21:0] W_IWB      = REGWE | DONE | A_ADD;
  localparam logic [21:0] W_TRAP     = ILL | A_ADD;

  logic [5:0]  fn_tab [5] = '{6'b100000, 6'b100010, 6'b100100, 6'b100101, 6'b101010};
  logic [21:0] al_tab [5] = '{A_ADD, A_SUB, A_AND, A_OR, A_SLT};

  function automatic logic [21:0] obs();
    return {bus.pc_we, bus.ir_we, bus.mdr_we, bus.ab_we, bus.alu_out_we,
            bus.mem_rd, bus.mem_wr, bus.iord, bus.reg_we, bus.reg_dst,
            bus.mem_to_reg, bus.alu_src_a, bus.alu_src_b, bus.alu_ctrl,
            bus.pc_src, bus.done, bus.illegal};
  endfunction

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_total++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  // Called at a falling edge: drive qualifiers, check state and outputs, wait one cycle
  task automatic step(input string tag, input logic mr, input logic z,
                      input logic [3:0] st, input logic [21:0] w);
    bus.mem_ready = mr;
    bus.zero      = z;
    #1;
    chk({tag, ".state"}, 32'(bus.state), 32'(st));
    chk({tag, ".out"}, 32'(obs()), 32'(w));
    @(negedge clk);
  endtask

  task automatic do_reset(input string tag);
    rst = 1'b1;
    #1;
    chk({tag, ".rst_state"}, 32'(bus.state), 32'd0);
    chk({tag, ".rst_out"}, 32'(obs()), 32'd0);
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    #1;
    chk({tag, ".rel_edge1"}, 32'(bus.state), 32'd0);
    @(negedge clk);
  endtask

  task automatic set_ir(input logic [5:0] op, input logic [5:0] fn);
    bus.opcode = op;
    bus.funct  = fn;
  endtask

  initial begin
    rst           = 1'b1;
    bus.opcode    = '0;
    bus.funct     = '0;
    bus.zero      = 1'b0;
    bus.mem_ready = 1'b0;
    @(negedge clk);
    do_reset("init");

    for (int i = 0; i < 5; i++) begin
      set_ir(6'b000000, fn_tab[i]);
      step("r.fetch", 1'b1, 1'b0, 4'd1, W_FETCH);
      step("r.dec",   1'b0, 1'b0, 4'd2, W_DEC);
      step("r.exec",  1'b1, 1'b0, 4'd7, SRCA | AOWE | al_tab[i]);
      step("r.wb",    1'b1, 1'b0, 4'd8, W_RWB);
    end

    set_ir(6'b100011, 6'b000000);
    step("lw.fetch", 1'b1, 1'b0, 4'd1, W_FETCH);
    step("lw.dec",   1'b1, 1'b0, 4'd2, W_DEC);
    step("lw.addr",  1'b1, 1'b0, 4'd3, W_MADDR);
    step("lw.wt0",   1'b0, 1'b0, 4'd4, W_MRD_WT);
    step("lw.wt1",   1'b0, 1'b0, 4'd4, W_MRD_WT);
    step("lw.rd",    1'b1, 1'b0, 4'd4, W_MRD);
    step("lw.wb",    1'b1, 1'b0, 4'd5, W_MWB);

    set_ir(6'b101011, 6'b000000);
    step("sw.fwt",   1'b0, 1'b0, 4'd1, W_FETCH_WT);
    step("sw.fetch", 1'b1, 1'b0, 4'd1, W_FETCH);
    step("sw.dec",   1'b1, 1'b0, 4'd2, W_DEC);
    step("sw.addr",  1'b0, 1'b0, 4'd3, W_MADDR);
    step("sw.wt",    1'b0, 1'b0, 4'd6, W_MWR_WT);
    step("sw.wr",    1'b1, 1'b0, 4'd6, W_MWR);

    set_ir(6'b000100, 6'b000000);
    step("beq1.fetch", 1'b1, 1'b1, 4'd1, W_FETCH);
    step("beq1.dec",   1'b1, 1'b1, 4'd2, W_DEC);
    step("beq1.br",    1'b1, 1'b1, 4'd9, W_BR_T);
    step("beq0.fetch", 1'b1, 1'b0, 4'd1, W_FETCH);
    step("beq0.dec",   1'b1, 1'b0, 4'd2, W_DEC);
    step("beq0.br",    1'b1, 1'b0, 4'd9, W_BR_N);

    set_ir(6'b000010, 6'b000000);
    step("j.fetch", 1'b1, 1'b0, 4'd1, W_FETCH);
    step("j.dec",   1'b1, 1'b0, 4'd2, W_DEC);
    step("j.jmp",   1'b1, 1'b0, 4'd10, W_JMP);

    set_ir(6'b001000, 6'b000000);
    step("addi.fetch", 1'b1, 1'b0, 4'd1, W_FETCH);
    step("addi.dec",   1'b1, 1'b0, 4'd2, W_DEC);
    step("addi.exec",  1'b0, 1'b0, 4'd11, W_MADDR);
    step("addi.wb",    1'b1, 1'b0, 4'd12, W_IWB);

    set_ir(6'b000101, 6'b000000);
    step("bne.fetch", 1'b1, 1'b0, 4'd1, W_FETCH);
    step("bne.dec",   1'b1, 1'b0, 4'd2, W_DEC);
`ifdef MC_CTRL_BNE_EN
    step("bne.br",    1'b1, 1'b0, 4'd9, W_BR_T);
`else
    step("bne.trap",  1'b1, 1'b0, 4'd15, W_TRAP);
    do_reset("bne");
`endif

    // Reset while stalled in MEM_RD
    set_ir(6'b100011, 6'b000000);
    step("lwr.fetch", 1'b1, 1'b0, 4'd1, W_FETCH);
    step("lwr.dec",   1'b1, 1'b0, 4'd2, W_DEC);
    step("lwr.addr",  1'b1, 1'b0, 4'd3, W_MADDR);
    bus.mem_ready = 1'b0;
    #1;
    chk("lwr.wait_state", 32'(bus.state), 32'd4);
    #2;
    do_reset("lwr");

    set_ir(6'b111111, 6'b000000);
    step("bop.fetch", 1'b1, 1'b0, 4'd1, W_FETCH);
    step("bop.dec",   1'b1, 1'b0, 4'd2, W_DEC);
    step("bop.trap0", 1'b1, 1'b1, 4'd15, W_TRAP);
    step("bop.trap1", 1'b0, 1'b0, 4'd15, W_TRAP);
    step("bop.trap2", 1'b1, 1'b1, 4'd15, W_TRAP);
    do_reset("bop");

    set_ir(6'b000000, 6'b000000);
    step("bfn.fetch", 1'b1, 1'b0, 4'd1, W_FETCH);
    step("bfn.dec",   1'b1, 1'b0, 4'd2, W_DEC);
    step("bfn.exec",  1'b1, 1'b0, 4'd7, SRCA | A_ADD);
    step("bfn.trap0", 1'b1, 1'b0, 4'd15, W_TRAP);
    step("bfn.trap1", 1'b1, 1'b1, 4'd15, W_TRAP);
    do_reset("bfn");

    set_ir(6'b001000, 6'b000000);
    step("post.fetch", 1'b1, 1'b0, 4'd1, W_FETCH);
    step("post.dec",   1'b1, 1'b0, 4'd2, W_DEC);

    $display("test done: total=%0d bad=%0d", n_total, n_bad);
    $finish;
  end

endmodule
